// File: rtl/arb_rr_4.sv
// Four-client arbiter with fixed or round-robin priority and a hold limit.
// Every handover passes through one idle cycle with no grant asserted.
module arb_rr_4 #(
    parameter int unsigned MAX_HOLD = 8,
    parameter bit          RR_EN    = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] req_i,
    output logic [3:0] gnt_o,
    output logic [1:0] gnt_id_o,
    output logic       busy_o
);

    localparam int unsigned CntW = $clog2(MAX_HOLD);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_HOLD - 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e          state_q, state_d;
    logic [3:0]      gnt_q, gnt_d;
    logic [1:0]      gnt_id_q, gnt_id_d;
    logic [1:0]      last_q, last_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    logic       others;
    logic       release_own;

    // Scan from highest to lowest priority; round-robin starts just below the last owner.
    always_comb begin
        win   = 2'd0;
        idx   = 2'd0;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = RR_EN ? (last_q - 2'(i)) : 2'(4 - i);
            if (!found && req_i[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        others      = |(req_i & ~gnt_q);
        release_own = !req_i[gnt_id_q] || ((cnt_q == CntMax) && others);
        unique case (state_q)
            StIdle: begin
                if (req_i != 4'b0000) begin
                    state_d  = StGrant;
                    gnt_d    = 4'b0001 << win;
                    gnt_id_d = win;
                    last_d   = win;
                    cnt_d    = '0;
                end
            end
            StGrant: begin
                if (release_own) begin
                    state_d = StIdle;
                    gnt_d   = 4'b0000;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            gnt_q    <= 4'b0000;
            gnt_id_q <= 2'd0;
            last_q   <= 2'd0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

    assign gnt_o    = gnt_q;
    assign gnt_id_o = gnt_id_q;
    assign busy_o   = (state_q == StGrant);

endmodule
